// File: rtl/load_store_buffer_pkg.sv
// Shared constants for the load/store buffer: sizing, FSM encoding, RV32 funct3 and mem_len codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package load_store_buffer_pkg;

  localparam int LSB_SIZE     = 8;
  localparam int ROB_ID_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_WAIT  = 2'd1,
    ST_STORE_WAIT = 2'd2,
    ST_DRAIN      = 2'd3
  } lsb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  // Access size is encoded directly in the low funct3 bits for both loads and stores.
  function automatic logic [1:0] f3_to_len(input logic [2:0] f3);
    return f3[1:0];
  endfunction

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// Load data extension: sign/zero-extends raw memory read data according to funct3.
// Latency: combinational.
// Backpressure: none.
// Ports: funct3 (load type), raw (read data, zero-filled above size), ext (32-bit result).
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    case (funct3)
      F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  ext = {24'b0, raw[7:0]};
      F3_LHU:  ext = {16'b0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store buffer between decode and memory; snoops CDBs, runs loads at head, stores after commit.
// Latency: head ready -> mem_req 1 cycle; mem_done -> lsb_cdb_en 1 cycle.
// Backpressure: lsb_full at count >= LSB_SIZE-1 (issue while full is dropped); rdy_in low freezes all state.
// Ports: clk/rst_in (sync, active high), rdy_in, flush_in; iss_* decoder issue; rs_cdb_* ALU broadcast;
//        store_commit_* ROB commit; lsb_full/lsb_busy status; lsb_cdb_* load result; mem_* memory port.
// Optional: define LSB_STAT_EN to add stat_loads/stat_stores completion counters.
module load_store_buffer #(
  parameter int LSB_SIZE     = load_store_buffer_pkg::LSB_SIZE,
  parameter int ROB_ID_WIDTH = load_store_buffer_pkg::ROB_ID_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    iss_en,
  input  logic                    iss_store,
  input  logic [2:0]              iss_funct3,
  input  logic [31:0]             iss_imm,
  input  logic [ROB_ID_WIDTH:0]   iss_lab1,
  input  logic [ROB_ID_WIDTH:0]   iss_lab2,
  input  logic [31:0]             iss_val1,
  input  logic [31:0]             iss_val2,
  input  logic [ROB_ID_WIDTH:0]   iss_tag,
  input  logic                    rs_cdb_en,
  input  logic [ROB_ID_WIDTH:0]   rs_cdb_lab,
  input  logic [31:0]             rs_cdb_val,
  input  logic                    store_commit_en,
  input  logic [ROB_ID_WIDTH:0]   store_commit_lab,
  output logic                    lsb_full,
  output logic                    lsb_busy,
  output logic                    lsb_cdb_en,
  output logic [ROB_ID_WIDTH:0]   lsb_cdb_lab,
  output logic [31:0]             lsb_cdb_val,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [1:0]              mem_len,
`ifdef LSB_STAT_EN
  output logic [31:0]             stat_loads,
  output logic [31:0]             stat_stores,
`endif
  input  logic                    mem_done,
  input  logic [31:0]             mem_rdata
);

  import load_store_buffer_pkg::*;

  localparam int PW = $clog2(LSB_SIZE);
  localparam int LW = ROB_ID_WIDTH + 1;
  typedef logic [PW-1:0] ptr_t;

  logic [LSB_SIZE-1:0] e_vld, e_store, e_rdy1, e_rdy2, e_comm;
  logic [2:0]          e_f3   [LSB_SIZE];
  logic [31:0]         e_imm  [LSB_SIZE];
  logic [31:0]         e_val1 [LSB_SIZE];
  logic [31:0]         e_val2 [LSB_SIZE];
  logic [LW-1:0]       e_lab1 [LSB_SIZE];
  logic [LW-1:0]       e_lab2 [LSB_SIZE];
  logic [LW-1:0]       e_tag  [LSB_SIZE];

  ptr_t       head, tail;
  logic [PW:0] count;
  lsb_state_t state_q, state_d;

  logic head_load_go, head_store_go;
  logic start_req, req_done, load_done, store_done, pop, push;
  logic [31:0] ext_val;

  // Label 0 means "no producer" and never matches a broadcast.
  function automatic logic cdb_hit(input logic en, input logic [LW-1:0] bl, input logic [LW-1:0] ol);
    return en && (bl != '0) && (bl == ol);
  endfunction

  assign lsb_full = (count >= (PW+1)'(LSB_SIZE - 1));
  assign lsb_busy = (state_q != ST_IDLE);
  assign push     = iss_en && !flush_in && !lsb_full;

  assign head_load_go  = e_vld[head] && !e_store[head] && e_rdy1[head];
  assign head_store_go = e_vld[head] &&  e_store[head] && e_rdy1[head] && e_rdy2[head] && e_comm[head];

  lsb_load_extend u_ext (
    .funct3 (e_f3[head]),
    .raw    (mem_rdata),
    .ext    (ext_val)
  );

  // Issue-time operand resolution, including same-cycle CDB bypass.
  logic        iss_rdy1, iss_rdy2;
  logic [31:0] iss_v1, iss_v2;
  always_comb begin
    iss_rdy1 = (iss_lab1 == '0);
    iss_v1   = iss_val1;
    iss_rdy2 = (iss_lab2 == '0);
    iss_v2   = iss_val2;
    if (!iss_rdy1) begin
      if (cdb_hit(rs_cdb_en, rs_cdb_lab, iss_lab1)) begin
        iss_rdy1 = 1'b1; iss_v1 = rs_cdb_val;
      end else if (cdb_hit(lsb_cdb_en, lsb_cdb_lab, iss_lab1)) begin
        iss_rdy1 = 1'b1; iss_v1 = lsb_cdb_val;
      end
    end
    if (!iss_rdy2) begin
      if (cdb_hit(rs_cdb_en, rs_cdb_lab, iss_lab2)) begin
        iss_rdy2 = 1'b1; iss_v2 = rs_cdb_val;
      end else if (cdb_hit(lsb_cdb_en, lsb_cdb_lab, iss_lab2)) begin
        iss_rdy2 = 1'b1; iss_v2 = lsb_cdb_val;
      end
    end
  end

  // Committed bits including this cycle's commit, so a flush sees a commit that lands with it.
  logic [LSB_SIZE-1:0] comm_nxt;
  always_comb begin
    comm_nxt = e_comm;
    if (store_commit_en) begin
      for (int i = 0; i < LSB_SIZE; i++) begin
        if (e_vld[i] && e_store[i] && (e_tag[i] == store_commit_lab)) comm_nxt[i] = 1'b1;
      end
    end
  end

  // Entries surviving a flush: the run of committed entries starting at head.
  logic [LSB_SIZE-1:0] keep;
  logic [PW:0]         n_keep;
  logic                run;
  ptr_t                idx;
  always_comb begin
    keep   = '0;
    n_keep = '0;
    run    = 1'b1;
    idx    = head;
    for (int i = 0; i < LSB_SIZE; i++) begin
      idx = head + ptr_t'(i);
      if (run && e_vld[idx] && comm_nxt[idx]) begin
        keep[idx] = 1'b1;
        n_keep    = n_keep + (PW+1)'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush_in) begin
          if (head_load_go)       state_d = ST_LOAD_WAIT;
          else if (head_store_go) state_d = ST_STORE_WAIT;
        end
      end
      ST_LOAD_WAIT: begin
        if (mem_done)      state_d = ST_IDLE;
        else if (flush_in) state_d = ST_DRAIN;
      end
      ST_STORE_WAIT: if (mem_done) state_d = ST_IDLE;
      ST_DRAIN:      if (mem_done) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // FSM: control strobes. A load completing under flush is discarded like a drain.
  always_comb begin
    start_req  = 1'b0;
    load_done  = 1'b0;
    store_done = 1'b0;
    pop        = 1'b0;
    req_done   = mem_done && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:       start_req = (state_d != ST_IDLE);
      ST_LOAD_WAIT:  if (mem_done && !flush_in) begin load_done = 1'b1; pop = 1'b1; end
      ST_STORE_WAIT: if (mem_done) begin store_done = 1'b1; pop = 1'b1; end
      default: ;
    endcase
  end

  // FSM: state register plus buffer datapath.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      e_vld       <= '0;
      e_store     <= '0;
      e_rdy1      <= '0;
      e_rdy2      <= '0;
      e_comm      <= '0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        e_f3[i]   <= '0;
        e_imm[i]  <= '0;
        e_val1[i] <= '0;
        e_val2[i] <= '0;
        e_lab1[i] <= '0;
        e_lab2[i] <= '0;
        e_tag[i]  <= '0;
      end
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_len     <= '0;
      lsb_cdb_en  <= 1'b0;
      lsb_cdb_lab <= '0;
      lsb_cdb_val <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;

      for (int i = 0; i < LSB_SIZE; i++) begin
        if (e_vld[i] && !e_rdy1[i]) begin
          if (cdb_hit(rs_cdb_en, rs_cdb_lab, e_lab1[i])) begin
            e_rdy1[i] <= 1'b1; e_val1[i] <= rs_cdb_val;
          end else if (cdb_hit(lsb_cdb_en, lsb_cdb_lab, e_lab1[i])) begin
            e_rdy1[i] <= 1'b1; e_val1[i] <= lsb_cdb_val;
          end
        end
        if (e_vld[i] && !e_rdy2[i]) begin
          if (cdb_hit(rs_cdb_en, rs_cdb_lab, e_lab2[i])) begin
            e_rdy2[i] <= 1'b1; e_val2[i] <= rs_cdb_val;
          end else if (cdb_hit(lsb_cdb_en, lsb_cdb_lab, e_lab2[i])) begin
            e_rdy2[i] <= 1'b1; e_val2[i] <= lsb_cdb_val;
          end
        end
      end
      e_comm <= comm_nxt;

      if (push) begin
        e_vld[tail]   <= 1'b1;
        e_store[tail] <= iss_store;
        e_f3[tail]    <= iss_funct3;
        e_imm[tail]   <= iss_imm;
        e_lab1[tail]  <= iss_lab1;
        e_lab2[tail]  <= iss_lab2;
        e_rdy1[tail]  <= iss_rdy1;
        e_rdy2[tail]  <= iss_rdy2;
        e_val1[tail]  <= iss_v1;
        e_val2[tail]  <= iss_v2;
        e_tag[tail]   <= iss_tag;
        e_comm[tail]  <= 1'b0;
      end

      if (pop) begin
        e_vld[head]  <= 1'b0;
        e_comm[head] <= 1'b0;
      end

      if (flush_in) begin
        for (int i = 0; i < LSB_SIZE; i++) begin
          if (!keep[i]) begin
            e_vld[i]  <= 1'b0;
            e_comm[i] <= 1'b0;
          end
        end
        tail  <= head + n_keep[PW-1:0];
        head  <= head + ptr_t'(pop);
        count <= n_keep - (PW+1)'(pop);
      end else begin
        tail  <= tail + ptr_t'(push);
        head  <= head + ptr_t'(pop);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end

      if (start_req) begin
        mem_req   <= 1'b1;
        mem_we    <= e_store[head];
        mem_addr  <= e_val1[head] + e_imm[head];
        mem_wdata <= e_store[head] ? e_val2[head] : 32'd0;
        mem_len   <= f3_to_len(e_f3[head]);
      end else if (req_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      lsb_cdb_en <= load_done;
      if (load_done) begin
        lsb_cdb_lab <= e_tag[head];
        lsb_cdb_val <= ext_val;
      end
    end
  end

`ifdef LSB_STAT_EN
  always_ff @(posedge clk) begin
    if (rst_in) begin
      stat_loads  <= '0;
      stat_stores <= '0;
    end else if (rdy_in) begin
      if (load_done)  stat_loads  <= stat_loads + 32'd1;
      if (store_done) stat_stores <= stat_stores + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed bench for load_store_buffer: loads, stores, commit gating, full/wrap, flush and drain.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_in, rdy_in, flush_in, iss_en, iss_store;
  logic [2:0]  iss_funct3;
  logic [31:0] iss_imm, iss_val1, iss_val2;
  logic [3:0]  iss_lab1, iss_lab2, iss_tag;
  logic        rs_cdb_en;
  logic [3:0]  rs_cdb_lab;
  logic [31:0] rs_cdb_val;
  logic        store_commit_en;
  logic [3:0]  store_commit_lab;
  logic        lsb_full, lsb_busy, lsb_cdb_en;
  logic [3:0]  lsb_cdb_lab;
  logic [31:0] lsb_cdb_val;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic        mem_done;
  logic [31:0] mem_rdata;
`ifdef LSB_STAT_EN
  logic [31:0] stat_loads, stat_stores;
`endif

  int checks = 0;
  int failures = 0;

  load_store_buffer dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .iss_en(iss_en), .iss_store(iss_store), .iss_funct3(iss_funct3), .iss_imm(iss_imm),
    .iss_lab1(iss_lab1), .iss_lab2(iss_lab2), .iss_val1(iss_val1), .iss_val2(iss_val2),
    .iss_tag(iss_tag), .rs_cdb_en(rs_cdb_en), .rs_cdb_lab(rs_cdb_lab), .rs_cdb_val(rs_cdb_val),
    .store_commit_en(store_commit_en), .store_commit_lab(store_commit_lab),
    .lsb_full(lsb_full), .lsb_busy(lsb_busy), .lsb_cdb_en(lsb_cdb_en),
    .lsb_cdb_lab(lsb_cdb_lab), .lsb_cdb_val(lsb_cdb_val),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_len(mem_len),
`ifdef LSB_STAT_EN
    .stat_loads(stat_loads), .stat_stores(stat_stores),
`endif
    .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                       input logic [3:0] l1, input logic [31:0] v1,
                       input logic [3:0] l2, input logic [31:0] v2, input logic [3:0] tag);
    iss_en = 1'b1; iss_store = st; iss_funct3 = f3; iss_imm = imm;
    iss_lab1 = l1; iss_val1 = v1; iss_lab2 = l2; iss_val2 = v2; iss_tag = tag;
    @(negedge clk);
    iss_en = 1'b0;
  endtask

  task automatic commit(input logic [3:0] lab);
    store_commit_en = 1'b1; store_commit_lab = lab;
    @(negedge clk);
    store_commit_en = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] lab, input logic [31:0] val);
    rs_cdb_en = 1'b1; rs_cdb_lab = lab; rs_cdb_val = val;
    @(negedge clk);
    rs_cdb_en = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata);
    mem_done = 1'b1; mem_rdata = rdata;
    @(negedge clk);
    mem_done = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic wait_req(output bit ok);
    int cyc = 0;
    while (!mem_req && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    ok = mem_req;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; iss_en = 1'b0; iss_store = 1'b0;
    iss_funct3 = 3'd0; iss_imm = 0; iss_val1 = 0; iss_val2 = 0; iss_lab1 = 0; iss_lab2 = 0;
    iss_tag = 0; rs_cdb_en = 0; rs_cdb_lab = 0; rs_cdb_val = 0; store_commit_en = 0;
    store_commit_lab = 0; mem_done = 0; mem_rdata = 0;
    tick(3);
    checks++; if ({mem_req, mem_we, lsb_full, lsb_busy, lsb_cdb_en} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {mem_req, mem_we, lsb_full, lsb_busy, lsb_cdb_en}); end
    checks++; if ({mem_addr, mem_wdata, mem_len, lsb_cdb_lab, lsb_cdb_val} !== '0) begin
      failures++; $display("FAIL reset_data got addr=%h wdata=%h len=%0d", mem_addr, mem_wdata, mem_len); end
    rst_in = 1'b0;
    tick(1);
  endtask

  task automatic test_load_word();
    issue(1'b0, 3'b010, 32'd4, 4'd0, 32'h100, 4'd0, 32'd0, 4'd5);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lw_early_req got=%b exp=0", mem_req); end
    tick(1);
    checks++; if ({mem_req, mem_we, mem_len} !== 4'b1010) begin
      failures++; $display("FAIL lw_req got req=%b we=%b len=%0d exp req=1 we=0 len=2", mem_req, mem_we, mem_len); end
    checks++; if (mem_addr !== 32'h104) begin failures++; $display("FAIL lw_addr got=%h exp=00000104", mem_addr); end
    respond(32'hDEADBEEF);
    checks++; if ({lsb_cdb_en, lsb_cdb_lab, mem_req} !== {1'b1, 4'd5, 1'b0}) begin
      failures++; $display("FAIL lw_cdb got en=%b lab=%0d req=%b exp en=1 lab=5 req=0", lsb_cdb_en, lsb_cdb_lab, mem_req); end
    checks++; if (lsb_cdb_val !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_val got=%h exp=deadbeef", lsb_cdb_val); end
    tick(1);
    checks++; if ({lsb_cdb_en, lsb_busy} !== 2'b00) begin
      failures++; $display("FAIL lw_pulse_end got en=%b busy=%b exp 0 0", lsb_cdb_en, lsb_busy); end
  endtask

  task automatic test_rdy_hold();
    issue(1'b0, 3'b010, 32'd0, 4'd0, 32'h500, 4'd0, 32'd0, 4'd1);
    tick(1);
    rdy_in = 1'b0; mem_done = 1'b1; mem_rdata = 32'h11;
    tick(2);
    mem_done = 1'b0;
    checks++; if ({mem_req, lsb_cdb_en, lsb_busy} !== 3'b101) begin
      failures++; $display("FAIL rdy_hold got req=%b cdb=%b busy=%b exp 1 0 1", mem_req, lsb_cdb_en, lsb_busy); end
    rdy_in = 1'b1;
    tick(1);
    respond(32'h22);
    checks++; if ({lsb_cdb_en, lsb_cdb_val} !== {1'b1, 32'h22}) begin
      failures++; $display("FAIL rdy_resume got en=%b val=%h exp en=1 val=00000022", lsb_cdb_en, lsb_cdb_val); end
    tick(1);
  endtask

  task automatic test_load_byte();
    issue(1'b0, 3'b000, 32'd0, 4'd3, 32'd0, 4'd0, 32'd0, 4'd6);
    tick(2);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL lb_blocked got=%b exp=0", mem_req); end
    cdb(4'd3, 32'h200);
    tick(1);
    checks++; if ({mem_req, mem_len, mem_addr} !== {1'b1, 2'd0, 32'h200}) begin
      failures++; $display("FAIL lb_req got req=%b len=%0d addr=%h exp 1 0 00000200", mem_req, mem_len, mem_addr); end
    respond(32'h80);
    checks++; if ({lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val} !== {1'b1, 4'd6, 32'hFFFFFF80}) begin
      failures++; $display("FAIL lb_sext got en=%b lab=%0d val=%h exp 1 6 ffffff80", lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val); end
    issue(1'b0, 3'b100, 32'd0, 4'd0, 32'h200, 4'd0, 32'd0, 4'd7);
    tick(1);
    respond(32'h80);
    checks++; if ({lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val} !== {1'b1, 4'd7, 32'h00000080}) begin
      failures++; $display("FAIL lbu_zext got en=%b lab=%0d val=%h exp 1 7 00000080", lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val); end
    // LH whose base arrives on the CDB in the issue cycle itself.
    rs_cdb_en = 1'b1; rs_cdb_lab = 4'd2; rs_cdb_val = 32'h300;
    issue(1'b0, 3'b001, 32'd2, 4'd2, 32'd0, 4'd0, 32'd0, 4'd3);
    rs_cdb_en = 1'b0;
    tick(1);
    checks++; if ({mem_req, mem_len, mem_addr} !== {1'b1, 2'd1, 32'h302}) begin
      failures++; $display("FAIL lh_bypass got req=%b len=%0d addr=%h exp 1 1 00000302", mem_req, mem_len, mem_addr); end
    respond(32'h8001);
    checks++; if (lsb_cdb_val !== 32'hFFFF8001) begin failures++; $display("FAIL lh_sext got=%h exp=ffff8001", lsb_cdb_val); end
    tick(1);
  endtask

  task automatic test_store_commit();
    bit seen = 0;
    issue(1'b1, 3'b010, 32'd8, 4'd0, 32'h400, 4'd0, 32'hCAFEF00D, 4'd2);
    for (int i = 0; i < 20; i++) begin
      if (mem_req) seen = 1;
      tick(1);
    end
    checks++; if (seen) begin failures++; $display("FAIL sw_uncommitted got req=1 exp=0"); end
    commit(4'd2);
    tick(1);
    checks++; if ({mem_req, mem_we, mem_len, mem_addr} !== {1'b1, 1'b1, 2'd2, 32'h408}) begin
      failures++; $display("FAIL sw_req got req=%b we=%b len=%0d addr=%h exp 1 1 2 00000408", mem_req, mem_we, mem_len, mem_addr); end
    checks++; if (mem_wdata !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_wdata got=%h exp=cafef00d", mem_wdata); end
    respond(32'd0);
    checks++; if ({mem_req, lsb_cdb_en} !== 2'b00) begin
      failures++; $display("FAIL sw_done got req=%b cdb=%b exp 0 0", mem_req, lsb_cdb_en); end
    tick(1);
    checks++; if (lsb_busy !== 1'b0) begin failures++; $display("FAIL sw_idle got busy=%b exp=0", lsb_busy); end
  endtask

  task automatic test_full_wrap();
    bit ok;
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, 3'b010, 32'(i * 4), 4'd8, 32'd0, 4'd0, 32'd0, 4'(i + 1));
      if (i == 5) begin
        checks++; if (lsb_full !== 1'b0) begin failures++; $display("FAIL full_at6 got=%b exp=0", lsb_full); end
      end
    end
    checks++; if ({lsb_full, mem_req} !== 2'b10) begin
      failures++; $display("FAIL full_at7 got full=%b req=%b exp 1 0", lsb_full, mem_req); end
    cdb(4'd8, 32'h1000);
    for (int i = 0; i < 7; i++) begin
      wait_req(ok);
      checks++; if (!ok || mem_addr !== 32'h1000 + 32'(i * 4)) begin
        failures++; $display("FAIL full_order%0d got req=%b addr=%h exp addr=%h", i, mem_req, mem_addr, 32'h1000 + 32'(i * 4)); end
      respond(32'(i));
      checks++; if ({lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val} !== {1'b1, 4'(i + 1), 32'(i)}) begin
        failures++; $display("FAIL full_cdb%0d got en=%b lab=%0d val=%h exp lab=%0d", i, lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val, i + 1); end
      if (i == 0) begin
        checks++; if (lsb_full !== 1'b0) begin failures++; $display("FAIL full_after_pop got=%b exp=0", lsb_full); end
      end
    end
    // 20 alternating load/store ops in batches of 4; pointers wrap several times.
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 4; j++) begin
        int k = b * 4 + j;
        issue(k[0], k[0] ? 3'b010 : 3'b010, 32'(k * 16), 4'd0, 32'h2000, 4'd0, 32'hA000 + 32'(k), 4'((k % 8) + 1));
      end
      for (int j = 1; j < 4; j += 2) commit(4'(((b * 4 + j) % 8) + 1));
      for (int j = 0; j < 4; j++) begin
        int k = b * 4 + j;
        wait_req(ok);
        checks++; if (!ok || mem_addr !== 32'h2000 + 32'(k * 16) || mem_we !== k[0]) begin
          failures++; $display("FAIL mix_req%0d got req=%b we=%b addr=%h exp we=%b addr=%h", k, mem_req, mem_we, mem_addr, k[0], 32'h2000 + 32'(k * 16)); end
        if (k[0]) begin
          checks++; if (mem_wdata !== 32'hA000 + 32'(k)) begin
            failures++; $display("FAIL mix_wdata%0d got=%h exp=%h", k, mem_wdata, 32'hA000 + 32'(k)); end
        end
        respond(32'h5500 + 32'(k));
        if (k[0]) begin
          checks++; if (lsb_cdb_en !== 1'b0) begin failures++; $display("FAIL mix_st_cdb%0d got=%b exp=0", k, lsb_cdb_en); end
        end else begin
          checks++; if ({lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val} !== {1'b1, 4'((k % 8) + 1), 32'h5500 + 32'(k)}) begin
            failures++; $display("FAIL mix_ld_cdb%0d got en=%b lab=%0d val=%h", k, lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val); end
        end
      end
    end
    tick(1);
  endtask

  task automatic test_flush_drain();
    bit ok;
    bit seen = 0;
    issue(1'b1, 3'b010, 32'd0, 4'd0, 32'h3000, 4'd0, 32'h11, 4'd1);
    issue(1'b1, 3'b010, 32'd4, 4'd0, 32'h3000, 4'd0, 32'h22, 4'd2);
    issue(1'b0, 3'b010, 32'd0, 4'd0, 32'h3100, 4'd0, 32'd0, 4'd3);
    issue(1'b0, 3'b010, 32'd0, 4'd0, 32'h3104, 4'd0, 32'd0, 4'd4);
    issue(1'b0, 3'b010, 32'd0, 4'd0, 32'h3108, 4'd0, 32'd0, 4'd5);
    commit(4'd1);
    commit(4'd2);
    wait_req(ok);
    checks++; if (!ok || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h3000, 32'h11}) begin
      failures++; $display("FAIL fd_st1 got we=%b addr=%h wdata=%h exp 1 00003000 00000011", mem_we, mem_addr, mem_wdata); end
    respond(32'd0);
    wait_req(ok);
    checks++; if (!ok || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h3004, 32'h22}) begin
      failures++; $display("FAIL fd_st2 got we=%b addr=%h wdata=%h exp 1 00003004 00000022", mem_we, mem_addr, mem_wdata); end
    respond(32'd0);
    wait_req(ok);
    checks++; if (!ok || {mem_we, mem_addr} !== {1'b0, 32'h3100}) begin
      failures++; $display("FAIL fd_ld1 got we=%b addr=%h exp 0 00003100", mem_we, mem_addr); end
    // Flush with a same-cycle issue that must be dropped.
    flush_in = 1'b1;
    issue(1'b0, 3'b010, 32'd0, 4'd0, 32'hBAD0, 4'd0, 32'd0, 4'd6);
    flush_in = 1'b0;
    checks++; if ({mem_req, lsb_busy} !== 2'b11) begin
      failures++; $display("FAIL fd_drain got req=%b busy=%b exp 1 1", mem_req, lsb_busy); end
    respond(32'h77);
    checks++; if ({lsb_cdb_en, mem_req} !== 2'b00) begin
      failures++; $display("FAIL fd_discard got cdb=%b req=%b exp 0 0", lsb_cdb_en, mem_req); end
    tick(1);
    checks++; if (lsb_busy !== 1'b0) begin failures++; $display("FAIL fd_idle got busy=%b exp=0", lsb_busy); end
    for (int i = 0; i < 10; i++) begin
      if (mem_req) seen = 1;
      tick(1);
    end
    checks++; if (seen) begin failures++; $display("FAIL fd_flushed_req got req=1 exp=0"); end
    issue(1'b0, 3'b010, 32'd0, 4'd0, 32'h3200, 4'd0, 32'd0, 4'd7);
    wait_req(ok);
    checks++; if (!ok || mem_addr !== 32'h3200) begin
      failures++; $display("FAIL fd_post_ld got req=%b addr=%h exp 1 00003200", mem_req, mem_addr); end
    respond(32'h99);
    checks++; if ({lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val} !== {1'b1, 4'd7, 32'h99}) begin
      failures++; $display("FAIL fd_post_cdb got en=%b lab=%0d val=%h exp 1 7 00000099", lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val); end
    tick(1);
  endtask

  task automatic test_flush_committed();
    bit ok;
    bit seen = 0;
    issue(1'b1, 3'b010, 32'd0, 4'd8, 32'd0, 4'd0, 32'hA1, 4'd1);
    issue(1'b1, 3'b010, 32'd0, 4'd0, 32'h4004, 4'd0, 32'hA2, 4'd2);
    issue(1'b1, 3'b010, 32'd0, 4'd0, 32'h4008, 4'd0, 32'hA3, 4'd3);
    commit(4'd1);
    commit(4'd2);
    flush_in = 1'b1;
    tick(1);
    flush_in = 1'b0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fc_blocked got req=%b exp=0", mem_req); end
    cdb(4'd8, 32'h4000);
    wait_req(ok);
    checks++; if (!ok || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h4000, 32'hA1}) begin
      failures++; $display("FAIL fc_st1 got we=%b addr=%h wdata=%h exp 1 00004000 000000a1", mem_we, mem_addr, mem_wdata); end
    respond(32'd0);
    wait_req(ok);
    checks++; if (!ok || {mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h4004, 32'hA2}) begin
      failures++; $display("FAIL fc_st2 got we=%b addr=%h wdata=%h exp 1 00004004 000000a2", mem_we, mem_addr, mem_wdata); end
    respond(32'd0);
    for (int i = 0; i < 15; i++) begin
      if (mem_req) seen = 1;
      tick(1);
    end
    checks++; if (seen || lsb_busy !== 1'b0 || lsb_full !== 1'b0) begin
      failures++; $display("FAIL fc_st3_dropped got req_seen=%b busy=%b full=%b exp 0 0 0", seen, lsb_busy, lsb_full); end
    issue(1'b0, 3'b010, 32'd0, 4'd0, 32'h4100, 4'd0, 32'd0, 4'd4);
    wait_req(ok);
    checks++; if (!ok || mem_addr !== 32'h4100) begin
      failures++; $display("FAIL fc_post_ld got req=%b addr=%h exp 1 00004100", mem_req, mem_addr); end
    respond(32'h5);
    checks++; if ({lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val} !== {1'b1, 4'd4, 32'h5}) begin
      failures++; $display("FAIL fc_post_cdb got en=%b lab=%0d val=%h exp 1 4 00000005", lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val); end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_rdy_hold();
    test_load_byte();
    test_store_commit();
    test_full_wrap();
    test_flush_drain();
    test_flush_committed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_buffer.md
Name: load_store_buffer

Overview:
- In-order circular buffer holding load/store micro-ops between decode and the memory controller.
- Snoops both CDB ports to resolve base and store-data operands.
- Executes loads at head; executes stores only after the reorder buffer commits them (store-commit pulse + label).
- Broadcasts load results on the LSB CDB port; obeys pipeline flush while preserving already-committed stores.

Parameters:
LSB_SIZE, 8, entry count (power of two)
ROB_ID_WIDTH, 3, label width minus 1; label 0 = "no dependency", valid labels 1..2**ROB_ID_WIDTH

Ports:
clk  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; when low all state holds and mem_req holds its value
flush_in  in  1  misprediction flush from reorder buffer
iss_en  in  1  new entry from decoder
iss_store  in  1  1=store, 0=load
iss_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
iss_imm  in  32  sign-extended offset
iss_lab1 / iss_lab2  in  ROB_ID_WIDTH+1  base / store-data producer labels (0 = value valid)
iss_val1 / iss_val2  in  32  base / store-data values when label is 0
iss_tag  in  ROB_ID_WIDTH+1  destination ROB label of this entry
rs_cdb_en, rs_cdb_lab, rs_cdb_val  in  1/ROB_ID_WIDTH+1/32  ALU broadcast
store_commit_en, store_commit_lab  in  1/ROB_ID_WIDTH+1  store committed by ROB
lsb_full  out  1  count >= LSB_SIZE-1
lsb_busy  out  1  memory FSM not IDLE
lsb_cdb_en, lsb_cdb_lab, lsb_cdb_val  out  1/ROB_ID_WIDTH+1/32  load result broadcast (one-cycle pulse)
mem_req, mem_we  out  1  request / write
mem_addr, mem_wdata  out  32  address / write data
mem_len  out  2  0=byte, 1=half, 2=word
mem_done, mem_rdata  in  1/32  completion pulse; rdata raw, zero-filled above mem_len

Behaviour:
- Reset (rst_in high at posedge): head=tail=count=0; all entries invalid; FSM IDLE. All outputs 0, including lsb_full, lsb_busy, lsb_cdb_en, mem_req and mem_we.
- Issue: on iss_en, write entry at tail and advance tail. Operands with label 0 are marked ready.
  - Same-cycle CDB bypass: an operand whose label matches an active CDB label this cycle enters ready with the CDB value.
  - iss_en while lsb_full is a protocol violation; the entry is dropped.
- Snoop: every cycle, each entry operand with a matching label from rs_cdb or lsb_cdb becomes ready with the broadcast value.
- Commit: store_commit_en sets the committed bit of the valid store whose tag equals store_commit_lab. At most one match is guaranteed.
- FSM states IDLE, LOAD_WAIT, STORE_WAIT, DRAIN.
  - IDLE to LOAD_WAIT: head is a load with base ready.
  - IDLE to STORE_WAIT: head is a store with both operands ready and committed.
  - On either transition: mem_req=1 next cycle; addr = val1 + imm (mod 2**32); mem_len = funct3[1:0]; mem_we = store.
  - mem_req stays high until the cycle mem_done is seen, then drops.
- LOAD_WAIT with mem_done:
  - Extend rdata: LB/LH sign-extend; LBU/LHU zero-extend.
  - Pulse lsb_cdb_en with the head's tag on the next cycle; pop head; go to IDLE.
- STORE_WAIT with mem_done: pop head, no broadcast; go to IDLE.
- Minimum latency: head ready to mem_req = 1 cycle; mem_done to lsb_cdb_en = 1 cycle.
- Flush:
  - All uncommitted entries are discarded; tail = head + number of committed entries. Committed stores are contiguous from head.
  - Pending lsb_cdb_en is suppressed.
  - STORE_WAIT continues (store is committed).
  - LOAD_WAIT goes to DRAIN: the outstanding request is kept until mem_done, whose data is discarded; then IDLE.
  - Flush and iss_en in the same cycle: flush wins, issue dropped.
- Simultaneous pop and issue: count unchanged. Pointers wrap modulo LSB_SIZE.
- No store-to-load forwarding; strict program order through head.

Optional Feature:
- LSB_STAT_EN: adds outputs stat_loads[31:0] and stat_stores[31:0], incremented on each completed (non-drained) load/store. Reset to 0; not cleared by flush.
- Without the macro: ports absent, no counters.

Decomposition:
- Shared package/header: LSB_SIZE, ROB_ID_WIDTH, FSM state encodings, funct3 constants (LB..SW), mem_len encodings.
- Sub-module lsb_load_extend: combinational funct3 + raw data to extended 32-bit value.
- Everything else in one module.

Test Plan:
- Load LW, base label 0, val1=0x100, imm=4 -> mem_req with addr 0x104, len 2; mem_done rdata=0xDEADBEEF -> lsb_cdb_val 0xDEADBEEF with the issued tag, one cycle after mem_done.
- LB with base label 3; rs_cdb lab=3 val=0x200 two cycles later -> request at 0x200; rdata 0x80 -> cdb_val 0xFFFFFF80. LBU with same data -> 0x00000080.
- SW operands ready, no commit -> no mem_req for 20 cycles; store_commit_en with its tag -> mem_req, we=1, wdata correct; mem_done -> head popped, no CDB pulse.
- Fill 7 entries -> lsb_full=1; one pop -> lsb_full=0; head/tail wrap after 20 mixed ops with correct order.
- Two committed stores plus three loads, flush while load in LOAD_WAIT (state reached after the committed stores drained, reissued scenario) -> DRAIN, rdata ignored, no CDB pulse; committed stores complete; count correct.
- Flush with two committed stores queued and one uncommitted -> both committed stores written to memory in order, third never requested.
